dp_mem_window_reader: RTL and testbench

- Read-side controller for a dual-port sample memory in the ECG feature path: the write side fills the memory as a circular buffer, and this block drains a window from it.
- On a start request it reads a window of consecutive samples, wrapping at the end of memory. It handles the memory's registered one-cycle read latency.
- Samples leave on a valid/ready stream toward the feature extractors, with full backpressure support.

---
 rtl/dp_mem_window_reader_pkg.sv | 20 ++
 rtl/dp_mem_window_reader_rd_skid_fifo2.sv | 68 ++++++
 rtl/dp_mem_window_reader.sv | 125 ++++++++++++
 tb/tb_dp_mem_window_reader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_mem_window_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_window_reader_pkg
// Description : Shared state encodings and sizing helpers for the window reader.
// Revision    : 1.0  initial release
// ============================================================================
package dp_mem_window_reader_pkg;

    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    // A window length must represent 0..MEM_DEPTH inclusive.
    function automatic int len_width(input int log2_depth);
        return log2_depth + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_mem_window_reader_rd_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : rd_skid_fifo2
// Description : Two-entry registered FIFO; the head register drives the output.
// Revision    : 1.0  initial release
// ============================================================================
module rd_skid_fifo2 #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_push_data;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_tail  <= i_push_data;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the entry behind the head moves up.
                    if (r_count == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dp_mem_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_window_reader
// Description : Drains a wrapping window from a registered-read sample memory
//               onto a valid/ready stream with full backpressure.
// Revision    : 1.0  initial release
// ============================================================================
module dp_mem_window_reader
    import dp_mem_window_reader_pkg::*;
#(
    parameter int MEM_DEPTH      = 16,
    parameter int LOG2_MEM_DEPTH = 4,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic                      start,
    input  logic [LOG2_MEM_DEPTH-1:0] start_addr,
    input  logic [LOG2_MEM_DEPTH:0]   win_len,
    output logic                      busy,
    output logic                      done,
    output logic [LOG2_MEM_DEPTH-1:0] mem_r_addr,
    output logic                      mem_r_en,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);

    localparam int                 c_LEN_W   = len_width(LOG2_MEM_DEPTH);
    localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MEM_DEPTH);

    logic [c_ST_W-1:0]         r_state;
    logic [LOG2_MEM_DEPTH-1:0] r_rd_addr;
    logic [c_LEN_W-1:0]        r_remaining;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_inflight;
    logic                      r_inflight_last;

    logic                      w_fifo_valid;
    logic [1:0]                w_fifo_count;
    logic [DATA_WIDTH:0]       w_fifo_head;
    logic                      w_pop;
    logic [2:0]                w_pending;
    logic                      w_issue;
    logic                      w_drained;

    assign w_pop = w_fifo_valid && out_ready;

    // Crediting this cycle's pop keeps a steady one-sample-per-cycle stream.
    assign w_pending = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue   = (r_state == c_ST_RUN) && (w_pending < 3'd2);
    assign w_drained = !r_inflight &&
                       ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_state         <= c_ST_IDLE;
            r_rd_addr       <= '0;
            r_remaining     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == c_LEN_W'(1));
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_rd_addr   <= start_addr;
                        r_remaining <= (win_len > c_MAX_LEN) ? c_MAX_LEN : win_len;
                        r_busy      <= 1'b1;
                        r_state     <= (win_len == '0) ? c_ST_FLUSH : c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_issue) begin
                        r_rd_addr   <= r_rd_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == c_LEN_W'(1)) begin
                            r_state <= c_ST_FLUSH;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    if (w_drained) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    rd_skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .aclr        (aclr),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, mem_data}),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    assign busy       = r_busy;
    assign done       = r_done;
    assign mem_r_en   = w_issue;
    assign mem_r_addr = r_rd_addr;
    assign out_valid  = w_fifo_valid;
    assign out_data   = w_fifo_head[DATA_WIDTH-1:0];
    assign out_last   = w_fifo_head[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_dp_mem_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_mem_window_reader
// Description : Scoreboard bench for dp_mem_window_reader with a registered-read
//               memory model and directed windows.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dp_mem_window_reader;

    logic        clk = 1'b0;
    logic        aclr;
    logic        start;
    logic [3:0]  start_addr;
    logic [4:0]  win_len;
    logic        busy;
    logic        done;
    logic [3:0]  mem_r_addr;
    logic        mem_r_en;
    logic [15:0] mem_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [15:0] mem [16];
    logic [16:0] exp_q [$];
    logic [3:0]  addr_q [$];
    logic [5:0]  pat = 6'b101001;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          outstanding = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_r_en) mem_data <= mem[mem_r_addr];
    end

    dp_mem_window_reader #(
        .MEM_DEPTH      (16),
        .LOG2_MEM_DEPTH (4),
        .DATA_WIDTH     (16)
    ) dut (
        .clk        (clk),
        .aclr       (aclr),
        .start      (start),
        .start_addr (start_addr),
        .win_len    (win_len),
        .busy       (busy),
        .done       (done),
        .mem_r_addr (mem_r_addr),
        .mem_r_en   (mem_r_en),
        .mem_data   (mem_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_mem_r_en"}, int'(mem_r_en), 0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_out_last"}, int'(out_last), 0);
        chk({nm, "_mem_r_addr"}, int'(mem_r_addr), 0);
        chk({nm, "_out_data"}, int'(out_data), 0);
    endtask

    // Monitor: checks every read address, every transfer and the read credit.
    initial begin
        int pop;
        logic [16:0] e;
        logic [3:0]  a;
        forever begin
            @(negedge clk);
            if (aclr) begin
                outstanding = 0;
            end else begin
                pop = (out_valid && out_ready) ? 1 : 0;
                if (out_valid && exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL stale_valid: got data 0x%0h expected no valid", out_data);
                end
                if (mem_r_en) begin
                    chk("read_credit_ok", int'(outstanding - pop < 2), 1);
                    if (addr_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL extra_read: got addr %0d expected no read", mem_r_addr);
                    end else begin
                        a = addr_q.pop_front();
                        chk("mem_r_addr", int'(mem_r_addr), int'(a));
                    end
                end
                if (pop == 1 && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("last_data", int'({out_last, out_data}), int'(e));
                end
                outstanding = outstanding + (mem_r_en ? 1 : 0) - pop;
            end
        end
    end

    task automatic run_window(input logic [3:0] a, input logic [4:0] len, input int rmode,
                              input int exp_first, input int exp_done,
                              input bit mid_start, input int abort_after);
        int n, k, first, last_k, xfers, pidx;
        bit seen_done;
        logic [3:0] ad;
        n = (len > 5'd16) ? 16 : int'(len);
        for (int i = 0; i < n; i++) begin
            ad = a + 4'(i);
            addr_q.push_back(ad);
            exp_q.push_back({(i == n - 1), 16'h1000 + 16'(ad)});
        end
        first = -1; last_k = -1; xfers = 0; pidx = 0; seen_done = 0;
        start = 1'b1; start_addr = a; win_len = len;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (k = 0; k < 300; k++) begin
            if (abort_after >= 0 && xfers == abort_after) break;
            start = (mid_start && k == 3);
            if (start) begin start_addr = 4'd9; win_len = 5'd3; end
            if (rmode != 0) begin out_ready = pat[pidx]; pidx = (pidx + 1) % 6; end
            else out_ready = 1'b1;
            if (out_valid && first < 0) first = k;
            if (done) begin seen_done = 1; break; end
            if (out_valid && out_ready) begin
                xfers++;
                if (out_last) last_k = k;
            end
            @(posedge clk); #2;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (abort_after >= 0) begin
            chk("delivered_before_abort", xfers, abort_after);
            aclr = 1'b1;
            @(posedge clk); #2;
            chk_all_zero("after_abort");
            aclr = 1'b0;
            exp_q.delete();
            addr_q.delete();
            repeat (4) @(posedge clk);
            #2;
            return;
        end
        if (!seen_done) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
            return;
        end
        chk("first_valid_cycle", first, exp_first);
        if (exp_done >= 0) chk("done_cycle", k, exp_done);
        if (n > 0) chk("done_after_last", k, last_k + 1);
        chk("busy_at_done", int'(busy), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("addr_q_empty", addr_q.size(), 0);
        @(posedge clk); #2;
        chk("done_one_pulse", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
        aclr = 1'b1; start = 1'b0; start_addr = '0; win_len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        aclr = 1'b0;
        @(posedge clk); #2;

        run_window(4'd3,  5'd4,  0, 2, 6,  0, -1);   // basic
        run_window(4'd14, 5'd5,  0, 2, 7,  0, -1);   // wrap 14,15,0,1,2
        run_window(4'd0,  5'd6,  1, 2, -1, 0, -1);   // ready 1,0,0,1,0,1
        run_window(4'd5,  5'd0,  0, -1, 1, 0, -1);   // empty window
        run_window(4'd7,  5'd16, 0, 2, 18, 0, -1);   // full memory
        run_window(4'd0,  5'd20, 0, 2, 18, 0, -1);   // clamped to 16
        run_window(4'd2,  5'd6,  0, 2, 8,  1, -1);   // start while busy
        run_window(4'd4,  5'd8,  0, 2, -1, 0, 2);    // reset mid-window
        run_window(4'd0,  5'd2,  0, 2, 4,  0, -1);   // recovery after reset

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
